// File: rtl/drive_actuator_arbiter.sv
// Arbitrates the single throttle/brake actuator pair between driver and cruise
// requesters, with dead time on hand-over, overspeed inhibit and latched emergency brake.
module drive_actuator_arbiter #(
    parameter int SPEED_W    = 8,
    parameter int MAX_SPEED  = 30,
    parameter int DEAD_CYC   = 2,
    parameter int EMERG_HOLD = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SPEED_W-1:0] speed,
    input  logic               obstacle,
    input  logic               drv_req,
    input  logic               drv_cmd,
    input  logic               cru_req,
    input  logic               cru_cmd,
    output logic               drv_gnt,
    output logic               cru_gnt,
    output logic               accelerate,
    output logic               brake,
    output logic               emergency
);

    localparam int CNT_MAX = (DEAD_CYC > EMERG_HOLD) ? DEAD_CYC : EMERG_HOLD;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0]   DEAD_INIT = CNT_W'(DEAD_CYC);
    localparam logic [CNT_W-1:0]   HOLD_LAST = CNT_W'(EMERG_HOLD);
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [SPEED_W-1:0] SPEED_LIM = SPEED_W'(MAX_SPEED);

    typedef enum logic [2:0] {
        IDLE,
        ACCEL,
        BRAKE,
        DEAD,
        EMERG
    } state_t;

    state_t           state, state_nx, arb_state;
    logic             owner_drv, owner_drv_nx;
    logic [CNT_W-1:0] cnt, cnt_nx, cnt_inc;
    logic             overspeed, drv_ok, cru_ok;
    logic             win_valid, win_drv, win_cmd, same_win;

    // An accelerate command at or above the speed limit is treated as no request.
    always_comb begin
        overspeed = (speed >= SPEED_LIM);
        drv_ok    = drv_req && !(!drv_cmd && overspeed);
        cru_ok    = cru_req && !(!cru_cmd && overspeed);
        win_valid = drv_ok || cru_ok;
        win_drv   = drv_ok;
        win_cmd   = drv_ok ? drv_cmd : cru_cmd;
        same_win  = win_valid && (win_drv == owner_drv) && (win_cmd == (state == BRAKE));
        cnt_inc   = (cnt >= HOLD_LAST) ? cnt : cnt + 1'b1;
        if (!win_valid) begin
            arb_state = IDLE;
        end else if (win_cmd) begin
            arb_state = BRAKE;
        end else begin
            arb_state = ACCEL;
        end
    end

    always_comb begin
        state_nx     = state;
        owner_drv_nx = owner_drv;
        cnt_nx       = cnt;
        if (obstacle) begin
            state_nx = EMERG;
            cnt_nx   = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nx     = arb_state;
                    owner_drv_nx = win_drv;
                    cnt_nx       = '0;
                end
                ACCEL, BRAKE: begin
                    if (!same_win) begin
                        state_nx = DEAD;
                        cnt_nx   = DEAD_INIT;
                    end
                end
                DEAD: begin
                    if (cnt <= CNT_ONE) begin
                        state_nx     = arb_state;
                        owner_drv_nx = win_drv;
                        cnt_nx       = '0;
                    end else begin
                        cnt_nx = cnt - 1'b1;
                    end
                end
                EMERG: begin
                    if (cnt_inc >= HOLD_LAST) begin
                        state_nx = DEAD;
                        cnt_nx   = DEAD_INIT;
                    end else begin
                        cnt_nx = cnt_inc;
                    end
                end
                default: begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they register on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner_drv  <= 1'b0;
            cnt        <= '0;
            drv_gnt    <= 1'b0;
            cru_gnt    <= 1'b0;
            accelerate <= 1'b0;
            brake      <= 1'b0;
            emergency  <= 1'b0;
        end else begin
            state      <= state_nx;
            owner_drv  <= owner_drv_nx;
            cnt        <= cnt_nx;
            drv_gnt    <= ((state_nx == ACCEL) || (state_nx == BRAKE)) && owner_drv_nx;
            cru_gnt    <= ((state_nx == ACCEL) || (state_nx == BRAKE)) && !owner_drv_nx;
            accelerate <= (state_nx == ACCEL);
            brake      <= (state_nx == BRAKE) || (state_nx == EMERG);
            emergency  <= (state_nx == EMERG);
        end
    end

endmodule

// File: tb/tb_drive_actuator_arbiter.sv
// Bench for drive_actuator_arbiter: directed vector table plus randomized run
// against a behavioural ownership model with invariant checks.
module tb_drive_actuator_arbiter;

    localparam int SPEED_W    = 8;
    localparam int MAX_SPEED  = 30;
    localparam int DEAD_CYC   = 2;
    localparam int EMERG_HOLD = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic [SPEED_W-1:0] speed;
    logic               obstacle, drv_req, drv_cmd, cru_req, cru_cmd;
    logic               drv_gnt, cru_gnt, accelerate, brake, emergency;

    drive_actuator_arbiter #(
        .SPEED_W   (SPEED_W),
        .MAX_SPEED (MAX_SPEED),
        .DEAD_CYC  (DEAD_CYC),
        .EMERG_HOLD(EMERG_HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .speed     (speed),
        .obstacle  (obstacle),
        .drv_req   (drv_req),
        .drv_cmd   (drv_cmd),
        .cru_req   (cru_req),
        .cru_cmd   (cru_cmd),
        .drv_gnt   (drv_gnt),
        .cru_gnt   (cru_gnt),
        .accelerate(accelerate),
        .brake     (brake),
        .emergency (emergency)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        int         spd;
        logic       obs, dreq, dcmd, creq, ccmd;
        logic [4:0] exp;  // {drv_gnt, cru_gnt, accelerate, brake, emergency}
    } vec_t;

    vec_t vecs[$];
    int   n_pass = 0;
    int   n_total = 0;

    // Model: who owns the actuator (0 none, 1 driver, 2 cruise), what it drives
    // (0 none, 1 accel, 2 brake), remaining dead cycles, emergency latch.
    int m_owner, m_act, m_dead, m_low;
    bit m_emerg;

    function automatic vec_t mk(input logic r, input int s, input logic o, input logic dq,
                                input logic dc, input logic cq, input logic cc,
                                input logic [4:0] e);
        vec_t v;
        v.rst = r; v.spd = s; v.obs = o; v.dreq = dq; v.dcmd = dc;
        v.creq = cq; v.ccmd = cc; v.exp = e;
        return v;
    endfunction

    function automatic void model_step(input bit r, input int s, input bit o, input bit dq,
                                       input bit dc, input bit cq, input bit cc);
        int who, cmd;
        who = 0;
        cmd = 0;
        if (dq && !(!dc && s >= MAX_SPEED)) begin
            who = 1; cmd = dc ? 2 : 1;
        end else if (cq && !(!cc && s >= MAX_SPEED)) begin
            who = 2; cmd = cc ? 2 : 1;
        end
        if (r) begin
            m_owner = 0; m_act = 0; m_dead = 0; m_low = 0; m_emerg = 0;
        end else if (o) begin
            m_emerg = 1; m_low = 0; m_owner = 0; m_act = 0; m_dead = 0;
        end else if (m_emerg) begin
            m_low++;
            if (m_low >= EMERG_HOLD) begin
                m_emerg = 0; m_low = 0; m_dead = DEAD_CYC;
            end
        end else if (m_owner != 0) begin
            if (who != m_owner || cmd != m_act) begin
                m_owner = 0; m_act = 0; m_dead = DEAD_CYC;
            end
        end else if (m_dead > 1) begin
            m_dead--;
        end else begin
            m_dead = 0; m_owner = who; m_act = cmd;
        end
    endfunction

    function automatic logic [4:0] model_out();
        return {m_owner == 1, m_owner == 2, m_act == 1, (m_act == 2) || m_emerg, m_emerg};
    endfunction

    task automatic drive(input logic r, input int s, input logic o, input logic dq,
                         input logic dc, input logic cq, input logic cc);
        reset = r; speed = SPEED_W'(s); obstacle = o;
        drv_req = dq; drv_cmd = dc; cru_req = cq; cru_cmd = cc;
    endtask

    task automatic check(input string name, input int idx, input logic [4:0] got,
                         input logic [4:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s[%0d] got {dg,cg,acc,brk,em}=%b expected %b", name, idx, got, exp);
    endtask

    logic [4:0] outs;
    assign outs = {drv_gnt, cru_gnt, accelerate, brake, emergency};

    initial begin
        // 1: reset held with request, then 1-cycle grant
        repeat (3) vecs.push_back(mk(1, 10, 0, 1, 0, 0, 0, 5'b00000));
        vecs.push_back(mk(0, 10, 0, 1, 0, 0, 0, 5'b10100));
        // 2: driver cmd flip -> two dead cycles, brake on third edge
        vecs.push_back(mk(0, 10, 0, 1, 1, 0, 0, 5'b00000));
        vecs.push_back(mk(0, 10, 0, 1, 1, 0, 0, 5'b00000));
        vecs.push_back(mk(0, 10, 0, 1, 1, 0, 0, 5'b10010));
        vecs.push_back(mk(0, 10, 0, 1, 1, 0, 0, 5'b10010));
        // 3: cruise preempted by driver brake
        vecs.push_back(mk(1, 10, 0, 0, 0, 0, 0, 5'b00000));
        vecs.push_back(mk(0, 10, 0, 0, 0, 1, 0, 5'b01100));
        vecs.push_back(mk(0, 10, 0, 1, 1, 1, 0, 5'b00000));
        vecs.push_back(mk(0, 10, 0, 1, 1, 1, 0, 5'b00000));
        vecs.push_back(mk(0, 10, 0, 1, 1, 1, 0, 5'b10010));
        vecs.push_back(mk(0, 10, 0, 1, 1, 1, 0, 5'b10010));
        // 4: overspeed inhibit and recovery
        vecs.push_back(mk(1, 12, 0, 0, 0, 0, 0, 5'b00000));
        vecs.push_back(mk(0, 12, 0, 1, 0, 0, 0, 5'b10100));
        repeat (4) vecs.push_back(mk(0, 30, 0, 1, 0, 0, 0, 5'b00000));
        vecs.push_back(mk(0, 29, 0, 1, 0, 0, 0, 5'b10100));
        // 5: reset mid-ACCEL drops outputs; emergency hold needs 4 consecutive lows
        vecs.push_back(mk(1, 10, 0, 1, 0, 0, 0, 5'b00000));
        vecs.push_back(mk(0, 10, 0, 1, 0, 0, 0, 5'b10100));
        vecs.push_back(mk(0, 10, 1, 1, 0, 0, 0, 5'b00011));
        repeat (3) vecs.push_back(mk(0, 10, 0, 1, 0, 0, 0, 5'b00011));
        vecs.push_back(mk(0, 10, 1, 1, 0, 0, 0, 5'b00011));
        repeat (3) vecs.push_back(mk(0, 10, 0, 1, 0, 0, 0, 5'b00011));
        vecs.push_back(mk(0, 10, 0, 1, 0, 0, 0, 5'b00000));
        vecs.push_back(mk(0, 10, 0, 1, 0, 0, 0, 5'b00000));
        vecs.push_back(mk(0, 10, 0, 1, 0, 0, 0, 5'b10100));
        // 6: obstacle during DEAD goes straight to EMERG
        vecs.push_back(mk(0, 10, 0, 0, 0, 0, 0, 5'b00000));
        vecs.push_back(mk(0, 10, 1, 0, 0, 0, 0, 5'b00011));
        vecs.push_back(mk(0, 10, 0, 0, 0, 0, 0, 5'b00011));

        drive(1, 10, 0, 0, 0, 0, 0);
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].spd, vecs[i].obs, vecs[i].dreq, vecs[i].dcmd,
                  vecs[i].creq, vecs[i].ccmd);
            @(posedge clk);
            #1;
            check("vec", i, outs, vecs[i].exp);
        end

        // Randomized run against the model, starting from reset.
        begin
            bit r, o, dq, dc, cq, cc;
            int s;
            r = 1; o = 0; dq = 0; dc = 0; cq = 0; cc = 0; s = 25;
            for (int cyc = 0; cyc < 10000; cyc++) begin
                if (cyc > 0) r = ($urandom_range(0, 999) == 0);
                o = ($urandom_range(0, 39) == 0);
                if ($urandom_range(0, 7) == 0) dq = !dq;
                if ($urandom_range(0, 7) == 0) cq = !cq;
                if ($urandom_range(0, 9) == 0) dc = !dc;
                if ($urandom_range(0, 9) == 0) cc = !cc;
                if ($urandom_range(0, 5) == 0) s = $urandom_range(24, 36);
                drive(r, s, o, dq, dc, cq, cc);
                model_step(r, s, o, dq, dc, cq, cc);
                @(posedge clk);
                #1;
                check("rand", cyc, outs, model_out());
                n_total++;
                if (!(accelerate && brake) && !(drv_gnt && cru_gnt) &&
                    (!(drv_gnt || cru_gnt) || (accelerate ^ brake)) &&
                    !(emergency && (drv_gnt || cru_gnt || accelerate)))
                    n_pass++;
                else
                    $display("FAIL invariant[%0d] got {dg,cg,acc,brk,em}=%b expected exclusive", cyc, outs);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
